// File: rtl/bitsim_enc_pkg.sv
// rtl/bitsim_enc_pkg.sv - shared widths and state encoding for the bit-index encoder
//
// Purpose: holds the vector/index widths and the encoder state type so the
// top and its priority-encoder helper agree on sizes.
// Ports:   none (package).
package bitsim_enc_pkg;

    localparam int VEC_W = 7;
    localparam int IDX_W = 3;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        BUSY = 1'b1
    } enc_state_e;

endpackage

// File: rtl/lsb_pri_enc_7to3.sv
// rtl/lsb_pri_enc_7to3.sv - lowest-set-bit priority encoder
//
// Purpose: combinational helper that finds the lowest set bit of a vector.
// Ports:
//   in_vec  [VEC_W-1:0]  vector to search
//   idx     [IDX_W-1:0]  index of the lowest set bit (0 when none set)
//   any                  1 when at least one bit is set
//   onehot  [VEC_W-1:0]  one-hot mask of the lowest set bit, used to clear it
module lsb_pri_enc_7to3
    import bitsim_enc_pkg::*;
(
    input  logic [VEC_W-1:0] in_vec,
    output logic [IDX_W-1:0] idx,
    output logic             any,
    output logic [VEC_W-1:0] onehot
);

    always_comb begin
        idx    = '0;
        onehot = '0;
        any    = |in_vec;
        // Scan from the top down so the last hit written is the lowest bit.
        for (int i = VEC_W - 1; i >= 0; i--) begin
            if (in_vec[i]) begin
                idx       = IDX_W'(i);
                onehot    = '0;
                onehot[i] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/bit_index_encoder_7to3.sv
// rtl/bit_index_encoder_7to3.sv - serial 7-bit vector to 3-bit index stream encoder
//
// Purpose: accepts a 7-bit bit-select vector and emits the index of each set
// bit, lowest first, one per beat. An all-zero vector emits a single beat
// with out_nz=0 so downstream beat/vector counting stays aligned.
// Ports:
//   clk       clock, rising edge
//   reset     synchronous active-high reset
//   in_vec    vector to encode
//   in_val    in_vec valid
//   in_rdy    encoder can take in_vec this cycle
//   out_idx   index of the current set bit (0 on the empty-vector beat)
//   out_nz    1 when out_idx names a real set bit
//   out_last  final beat of the current vector
//   out_val   output beat valid
//   out_rdy   downstream accepts the beat
module bit_index_encoder_7to3
    import bitsim_enc_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic [VEC_W-1:0] in_vec,
    input  logic             in_val,
    output logic             in_rdy,
    output logic [IDX_W-1:0] out_idx,
    output logic             out_nz,
    output logic             out_last,
    output logic             out_val,
    input  logic             out_rdy
);

    localparam logic [VEC_W-1:0] VEC_ONE = VEC_W'(1);

    enc_state_e       state_q,     state_d;
    logic [VEC_W-1:0] resid_q,     resid_d;
    logic             zero_pend_q, zero_pend_d;

    logic [IDX_W-1:0] pe_idx;
    logic             pe_any;
    logic [VEC_W-1:0] pe_onehot;

    logic busy;
    logic single_bit;
    logic beat;
    logic accept;

    lsb_pri_enc_7to3 u_pri_enc (
        .in_vec (resid_q),
        .idx    (pe_idx),
        .any    (pe_any),
        .onehot (pe_onehot)
    );

    // Clearing the lowest set bit leaves zero exactly when one bit was set.
    assign single_bit = pe_any && ((resid_q & (resid_q - VEC_ONE)) == '0);

    assign busy     = (state_q == BUSY);
    assign out_val  = busy && !reset;
    assign out_nz   = out_val && pe_any;
    assign out_idx  = out_nz ? pe_idx : '0;
    assign out_last = out_val && (zero_pend_q || single_bit);

    assign beat   = out_val && out_rdy;
    // Accepting on the last beat's handshake keeps consecutive vectors bubble-free.
    assign in_rdy = !reset && (!busy || (beat && out_last));
    assign accept = in_val && in_rdy;

    always_comb begin
        state_d     = state_q;
        resid_d     = resid_q;
        zero_pend_d = zero_pend_q;

        if (beat) begin
            resid_d     = resid_q & ~pe_onehot;
            zero_pend_d = 1'b0;
            if (out_last) begin
                state_d = IDLE;
            end
        end

        // A new vector overrides the drain of the finishing one.
        if (accept) begin
            resid_d     = in_vec;
            zero_pend_d = (in_vec == '0);
            state_d     = BUSY;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            resid_q     <= '0;
            zero_pend_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            resid_q     <= resid_d;
            zero_pend_q <= zero_pend_d;
        end
    end

endmodule

// File: tb/tb_bit_index_encoder_7to3.sv
// tb/tb_bit_index_encoder_7to3.sv - scoreboard bench for bit_index_encoder_7to3
module tb_bit_index_encoder_7to3;

    logic       clk = 1'b0;
    logic       reset;
    logic [6:0] in_vec;
    logic       in_val;
    logic       in_rdy;
    logic [2:0] out_idx;
    logic       out_nz;
    logic       out_last;
    logic       out_val;
    logic       out_rdy;

    always #5 clk = ~clk;

    bit_index_encoder_7to3 dut (
        .clk      (clk),
        .reset    (reset),
        .in_vec   (in_vec),
        .in_val   (in_val),
        .in_rdy   (in_rdy),
        .out_idx  (out_idx),
        .out_nz   (out_nz),
        .out_last (out_last),
        .out_val  (out_val),
        .out_rdy  (out_rdy)
    );

    typedef struct packed {
        logic [2:0] idx;
        logic       nz;
        logic       last;
    } beat_t;

    beat_t sb[$];
    beat_t exp_beat;
    beat_t prev_beat;
    logic  prev_stall = 1'b0;
    int    n_checks = 0;
    int    n_pass = 0;

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endfunction

    function automatic void push_exp(input logic [2:0] idx, input logic nz, input logic last);
        beat_t b;
        b.idx  = idx;
        b.nz   = nz;
        b.last = last;
        sb.push_back(b);
    endfunction

    // Monitor: pops an expected beat on every handshake, and checks outputs
    // are frozen during stalls.
    always @(negedge clk) begin
        if (!reset) begin
            if (prev_stall)
                check("stall_hold", {28'd0, out_val, out_idx, out_nz, out_last}, {28'd0, 1'b1, prev_beat});
            if (out_val && out_rdy) begin
                if (sb.size() == 0) begin
                    n_checks++;
                    $display("FAIL unexpected_beat: got idx=%0d nz=%0d last=%0d expected no beat",
                             out_idx, out_nz, out_last);
                end else begin
                    exp_beat = sb.pop_front();
                    check("beat", {27'd0, out_idx, out_nz, out_last}, {27'd0, exp_beat});
                end
            end
        end
        prev_stall <= !reset && out_val && !out_rdy;
        prev_beat  <= {out_idx, out_nz, out_last};
    end

    // Presents v and returns one step after the accepting edge, in_val dropped.
    task automatic offer(input logic [6:0] v);
        int t = 0;
        in_vec = v;
        in_val = 1'b1;
        @(negedge clk);
        while (!in_rdy && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (!in_rdy) check("accept_timeout", 32'(in_rdy), 32'd1);
        @(posedge clk);
        #1;
        in_val = 1'b0;
    endtask

    task automatic drain(input string name);
        int t = 0;
        while (sb.size() != 0 && t < 300) begin
            @(posedge clk);
            #1;
            t++;
        end
        check(name, 32'(sb.size()), 32'd0);
    endtask

    initial begin
        reset   = 1'b1;
        in_val  = 1'b1;
        in_vec  = 7'b1010101;
        out_rdy = 1'b1;

        // Reset held three cycles with in_val high.
        repeat (3) begin
            @(negedge clk);
            check("reset_in_rdy", 32'(in_rdy), 32'd0);
            check("reset_out_val", 32'(out_val), 32'd0);
        end
        @(posedge clk);
        #1;
        reset  = 1'b0;
        in_val = 1'b0;
        @(negedge clk);
        check("post_reset_in_rdy", 32'(in_rdy), 32'd1);

        // Sparse vector: idx 1,4,6; in_rdy only on the last beat.
        push_exp(3'd1, 1'b1, 1'b0);
        push_exp(3'd4, 1'b1, 1'b0);
        push_exp(3'd6, 1'b1, 1'b1);
        @(posedge clk);
        #1;
        offer(7'b1010010);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("sparse_out_val", 32'(out_val), 32'd1);
            check("sparse_in_rdy", 32'(in_rdy), (k == 2) ? 32'd1 : 32'd0);
        end
        @(posedge clk);
        #1;
        drain("sparse_drain");

        // Zero vector: one empty beat, then idle.
        push_exp(3'd0, 1'b0, 1'b1);
        offer(7'b0000000);
        @(negedge clk);
        check("zero_out_val", 32'(out_val), 32'd1);
        @(negedge clk);
        check("zero_idle", 32'(out_val), 32'd0);
        @(posedge clk);
        #1;
        drain("zero_drain");

        // Full vector under random backpressure.
        for (int i = 0; i < 7; i++) push_exp(3'(i), 1'b1, (i == 6));
        offer(7'b1111111);
        for (int t = 0; t < 400 && sb.size() != 0; t++) begin
            out_rdy = 1'($urandom_range(0, 1));
            @(negedge clk);
            @(posedge clk);
            #1;
        end
        out_rdy = 1'b1;
        drain("bp_drain");
        @(negedge clk);
        check("bp_idle", 32'(out_val), 32'd0);
        @(posedge clk);
        #1;

        // Back-to-back: B accepted on A's last beat, no bubble.
        push_exp(3'd0, 1'b1, 1'b1);
        push_exp(3'd6, 1'b1, 1'b1);
        in_vec = 7'b0000001;
        in_val = 1'b1;
        @(negedge clk);
        check("b2b_a_rdy", 32'(in_rdy), 32'd1);
        @(posedge clk);
        #1;
        in_vec = 7'b1000000;
        @(negedge clk);
        check("b2b_b_rdy", 32'(in_rdy), 32'd1);
        check("b2b_a_last", 32'(out_last), 32'd1);
        @(posedge clk);
        #1;
        in_val = 1'b0;
        @(negedge clk);
        check("b2b_b_val", 32'(out_val), 32'd1);
        check("b2b_b_idx", 32'(out_idx), 32'd6);
        @(posedge clk);
        #1;
        drain("b2b_drain");

        // Mid-stream reset after the first beat discards the rest.
        push_exp(3'd1, 1'b1, 1'b0);
        offer(7'b0110110);
        @(negedge clk);
        @(posedge clk);
        #1;
        reset = 1'b1;
        repeat (2) begin
            @(negedge clk);
            check("midrst_out_val", 32'(out_val), 32'd0);
            check("midrst_in_rdy", 32'(in_rdy), 32'd0);
        end
        @(posedge clk);
        #1;
        reset = 1'b0;
        repeat (4) begin
            @(negedge clk);
            check("midrst_after", 32'(out_val), 32'd0);
        end
        check("midrst_sb_empty", 32'(sb.size()), 32'd0);

        @(posedge clk);
        #1;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
